mantissa_multiplier_seq: RTL
============================

MANTISSA_MULTIPLIER_SEQ -- requirements
Module: mantissa_multiplier_seq

Interface
REQ-001 The module SHALL have parameter MANT_W, default 24: the significand width including the hidden bit.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port start, input, 1 bit: request a multiply; sampled only while ready=1.
REQ-005 The module SHALL have port mant_a, input, MANT_W bits: operand A significand, hidden bit supplied by the caller.
REQ-006 The module SHALL have port mant_b, input, MANT_W bits: operand B significand, hidden bit supplied by the caller.
REQ-007 The module SHALL have port ready, output, 1 bit: high only in state IDLE.
REQ-008 The module SHALL have port busy, output, 1 bit: high only in state CALC.
REQ-009 The module SHALL have port done, output, 1 bit: one-cycle pulse, high only in state DONE.
REQ-010 The module SHALL have port product, output, 2*MANT_W bits: unsigned product mant_a*mant_b.
REQ-011 The module SHALL have port norm_shift, output, 1 bit: equals product[2*MANT_W-1]; drives the downstream exponent +1 stage.

Function
REQ-012 The FSM SHALL have exactly three states, IDLE, CALC and DONE, with transitions IDLE->CALC on start, CALC->DONE after MANT_W iterations, and DONE->IDLE unconditionally.
REQ-013 On the edge where start=1 in IDLE, the module SHALL capture mant_a and mant_b into internal registers, clear the accumulator, and clear the iteration counter.
REQ-014 While start=0, the FSM SHALL remain in IDLE with all outputs held.
REQ-015 Each CALC cycle SHALL perform one radix-2 shift-add step: if the multiplier LSB is 1, add the multiplicand into the upper MANT_W+1 accumulator bits; then shift the accumulator and the multiplier right by 1.
REQ-016 The iteration counter SHALL be $clog2(MANT_W+1) bits wide, SHALL increment once per CALC cycle, and SHALL leave CALC when it reaches MANT_W-1.
REQ-017 The add SHALL keep its carry-out, so the full 2*MANT_W-bit result is exact with no truncation.
REQ-018 Latency SHALL be fixed: done is high in the cycle after the (MANT_W+1)th rising edge following the edge that sampled start.
REQ-019 Throughput SHALL be one result per MANT_W+2 cycles.
REQ-020 The product and norm_shift outputs SHALL update only on entry to DONE, and SHALL hold that value until the next entry to DONE or until reset.
REQ-021 A start asserted while not in IDLE SHALL be ignored, with no effect on the operation in flight or its result.
REQ-022 Operand inputs SHALL be don't-care outside the start-sampling edge, and changes to them mid-operation SHALL NOT affect the result.

Reset
REQ-023 When rst=1 on a clock edge, the FSM SHALL go to IDLE and the accumulator, counter, product and norm_shift SHALL go to 0.
REQ-024 In the cycle after that reset edge, the outputs SHALL be ready=1, busy=0, done=0, product=0 and norm_shift=0.
REQ-025 A reset asserted during CALC or DONE SHALL abort the operation, and no done pulse SHALL be produced for it.
REQ-026 When rst and start are both 1 on the same edge, rst SHALL take priority and start SHALL be discarded.

Configuration
REQ-027 When macro MANT_MUL_EARLY_ZERO_EN is defined, a start with mant_a==0 or mant_b==0 SHALL go IDLE->DONE directly, giving product=0, norm_shift=0, and done high in the cycle after the sampling edge.
REQ-028 When MANT_MUL_EARLY_ZERO_EN is not defined, zero operands SHALL take the full CALC path with the latency of REQ-018 and SHALL still yield product=0.

Verification
REQ-029 Scenario 1.0x1.0: MANT_W=24, mant_a=mant_b=0x800000 -> product=0x400000000000, norm_shift=0, done exactly 25 edges after the start edge.
REQ-030 Scenario 1.5x1.5: mant_a=mant_b=0xC00000 -> product=0x900000000000, norm_shift=1.
REQ-031 Scenario max x max: mant_a=mant_b=0xFFFFFF -> product=0xFFFFFE000001, norm_shift=1.
REQ-032 Scenario start while busy: pulse start with new operands at CALC cycle 10 -> result unchanged from the first operands, exactly one done pulse, ready=1 on the following cycle.
REQ-033 Scenario reset mid-operation: assert rst at CALC cycle 12 -> next cycle ready=1, busy=0, product=0, and no done pulse for that operation.
REQ-034 Scenario zero operand: mant_a=0, mant_b=0xABCDEF -> product=0; with MANT_MUL_EARLY_ZERO_EN, done 1 edge after start; without it, done after 25 edges.

Source files
------------

// File: rtl/mantissa_multiplier_seq.sv
// mantissa_multiplier_seq: radix-2 sequential shift-add significand multiplier.
// One partial product per CALC cycle; the MANT_W x MANT_W result is exact (2*MANT_W bits).
// Optional build macro MANT_MUL_EARLY_ZERO_EN: a zero operand skips CALC and goes
// straight to DONE with product=0.
module mantissa_multiplier_seq #(
  parameter int MANT_W = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [MANT_W-1:0]     mant_a,
  input  logic [MANT_W-1:0]     mant_b,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [2*MANT_W-1:0]   product,
  output logic                  norm_shift
);

  localparam int CNT_W = $clog2(MANT_W+1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MANT_W-1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state, state_nxt;
  logic [MANT_W-1:0]     mcand;
  logic [MANT_W-1:0]     mplier;
  logic [2*MANT_W-1:0]   acc;
  logic [2*MANT_W-1:0]   acc_step;
  logic [MANT_W:0]       upper_sum;
  logic [CNT_W-1:0]      cnt;
  logic                  zero_op;

`ifdef MANT_MUL_EARLY_ZERO_EN
  assign zero_op = (mant_a == '0) || (mant_b == '0);
`else
  assign zero_op = 1'b0;
`endif

  assign ready = (state == IDLE);
  assign busy  = (state == CALC);
  assign done  = (state == DONE);

  // One shift-add step: add multiplicand into the upper half keeping the carry,
  // then the carry drops into the MSB as the whole accumulator shifts right.
  always_comb begin
    upper_sum = {1'b0, acc[2*MANT_W-1:MANT_W]} + (mplier[0] ? {1'b0, mcand} : '0);
    acc_step  = {upper_sum, acc[MANT_W-1:1]};
  end

  // State register; reset wins over everything including start.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: IDLE->CALC on start (or ->DONE on zero operand when enabled),
  // CALC->DONE after the last iteration, DONE->IDLE always.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = zero_op ? DONE : CALC;
      CALC:    if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture in IDLE, iteration in CALC, result latch on DONE entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      cnt        <= '0;
      product    <= '0;
      norm_shift <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mcand  <= mant_a;
          mplier <= mant_b;
          acc    <= '0;
          cnt    <= '0;
          if (zero_op) begin
            product    <= '0;
            norm_shift <= 1'b0;
          end
        end
        CALC: begin
          acc    <= acc_step;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            product    <= acc_step;
            norm_shift <= acc_step[2*MANT_W-1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
